multi_port_ram_arb: RTL and testbench

Parametrised multi-port synchronous RAM with independent write and read port counts, per-byte write enables, and deterministic write-collision arbitration. Read-during-write behaviour is selectable, and read latency is configurable. A hardware clear engine zeroes the whole array after every reset. It is the next-generation storage primitive for register files and small shared buffers, and a drop-in where a fixed N-read/N-write memory was used before.

---
 rtl/multi_port_ram_arb.sv | 175 +++++++++++++++++
 tb/tb_multi_port_ram_arb.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : multi_port_ram_arb
// Brief    : Multi-port synchronous RAM with byte-lane writes, lowest-port-wins
//            write arbitration, collision reporting and a post-reset clear engine.
// Revision : 1.0 - initial release
// ============================================================================
module multi_port_ram_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_WR     = 4,
    parameter int NUM_RD     = 4,
    parameter int BYTE_W     = 8,
    parameter int RDW_MODE   = 0,
    parameter int RD_LAT     = 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_WR-1:0]                        we,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]             waddr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]             wdata,
    input  logic [NUM_WR*(DATA_WIDTH/BYTE_W)-1:0]    wbe,
    input  logic [NUM_RD-1:0]                        re,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]             raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0]             rdata,
    output logic [NUM_RD-1:0]                        rvalid,
    output logic                                     init_busy,
    output logic                                     wr_collision,
    output logic [15:0]                              collision_cnt
);

    localparam int c_depth = 1 << ADDR_WIDTH;
    localparam int c_nb    = DATA_WIDTH / BYTE_W;
    localparam logic [ADDR_WIDTH-1:0] c_last = ADDR_WIDTH'(c_depth - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [ADDR_WIDTH-1:0]           r_init_cnt;
    logic [DATA_WIDTH-1:0]           r_mem     [c_depth];
    logic [DATA_WIDTH-1:0]           w_mem_nxt [c_depth];
    logic                            w_run;
    logic                            w_coll;
    logic [NUM_RD*DATA_WIDTH-1:0]    w_rd_word;
    logic [NUM_RD*DATA_WIDTH-1:0]    r_rdata1;
    logic [NUM_RD-1:0]               r_rvalid1;
    logic                            r_wr_collision;
    logic [15:0]                     r_collision_cnt;

    assign w_run     = (r_state == ST_RUN);
    assign init_busy = (r_state == ST_INIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_init_cnt == c_last) begin
            w_state_nxt = ST_RUN;
        end
    end

    // Ports are applied highest index first so the lowest enabled port owns each lane.
    always_comb begin
        w_mem_nxt = r_mem;
        if (!w_run) begin
            w_mem_nxt[r_init_cnt] = '0;
        end else begin
            for (int p = NUM_WR - 1; p >= 0; p--) begin
                if (we[p]) begin
                    for (int b = 0; b < c_nb; b++) begin
                        if (wbe[p*c_nb + b]) begin
                            w_mem_nxt[waddr[p*ADDR_WIDTH +: ADDR_WIDTH]][b*BYTE_W +: BYTE_W] =
                                wdata[p*DATA_WIDTH + b*BYTE_W +: BYTE_W];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        r_mem <= w_mem_nxt;
    end

    always_comb begin
        w_coll = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (we[i] && we[j] &&
                    waddr[i*ADDR_WIDTH +: ADDR_WIDTH] == waddr[j*ADDR_WIDTH +: ADDR_WIDTH] &&
                    |(wbe[i*c_nb +: c_nb] & wbe[j*c_nb +: c_nb])) begin
                    w_coll = 1'b1;
                end
            end
        end
    end

    // New-data mode reads the merged next-state word, giving write-through bypass.
    always_comb begin
        w_rd_word = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            if (RDW_MODE != 0) begin
                w_rd_word[j*DATA_WIDTH +: DATA_WIDTH] = w_mem_nxt[raddr[j*ADDR_WIDTH +: ADDR_WIDTH]];
            end else begin
                w_rd_word[j*DATA_WIDTH +: DATA_WIDTH] = r_mem[raddr[j*ADDR_WIDTH +: ADDR_WIDTH]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_collision  <= 1'b0;
            r_collision_cnt <= '0;
            r_rdata1        <= '0;
            r_rvalid1       <= '0;
        end else begin
            r_wr_collision <= w_coll && w_run;
            if (w_coll && w_run && r_collision_cnt != 16'hFFFF) begin
                r_collision_cnt <= r_collision_cnt + 16'd1;
            end
            for (int j = 0; j < NUM_RD; j++) begin
                r_rvalid1[j] <= re[j] && w_run;
                if (re[j] && w_run) begin
                    r_rdata1[j*DATA_WIDTH +: DATA_WIDTH] <= w_rd_word[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign wr_collision  = r_wr_collision;
    assign collision_cnt = r_collision_cnt;

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [NUM_RD*DATA_WIDTH-1:0] r_rdata2;
            logic [NUM_RD-1:0]            r_rvalid2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rdata2  <= '0;
                    r_rvalid2 <= '0;
                end else begin
                    r_rvalid2 <= r_rvalid1;
                    for (int j = 0; j < NUM_RD; j++) begin
                        if (r_rvalid1[j]) begin
                            r_rdata2[j*DATA_WIDTH +: DATA_WIDTH] <= r_rdata1[j*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
            end

            assign rdata  = r_rdata2;
            assign rvalid = r_rvalid2;
        end else begin : g_lat1
            assign rdata  = r_rdata1;
            assign rvalid = r_rvalid1;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_port_ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_port_ram_arb
// Brief    : Directed bench; dut0 = old-data/latency 1, dut1 = new-data/latency 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_port_ram_arb;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NW = 4;
    localparam int NR = 4;
    localparam int NB = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic [NW*NB-1:0] wbe;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] raddr;

    logic [NR*DW-1:0] rdata0, rdata1;
    logic [NR-1:0]    rvalid0, rvalid1;
    logic             busy0, busy1, coll0, coll1;
    logic [15:0]      cnt0, cnt1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_port_ram_arb #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WR(NW), .NUM_RD(NR),
        .BYTE_W(8), .RDW_MODE(0), .RD_LAT(1)
    ) dut0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re(re), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0),
        .init_busy(busy0), .wr_collision(coll0), .collision_cnt(cnt0)
    );

    multi_port_ram_arb #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WR(NW), .NUM_RD(NR),
        .BYTE_W(8), .RDW_MODE(1), .RD_LAT(2)
    ) dut1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re(re), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1),
        .init_busy(busy1), .wr_collision(coll1), .collision_cnt(cnt1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in;
        we = '0; waddr = '0; wdata = '0; wbe = '0; re = '0; raddr = '0;
    endtask

    task automatic drv_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [NB-1:0] be);
        we[p] = 1'b1;
        waddr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
        wbe[p*NB +: NB]   = be;
    endtask

    task automatic drv_rd(input int p, input logic [AW-1:0] a);
        re[p] = 1'b1;
        raddr[p*AW +: AW] = a;
    endtask

    // Walks the 16 clear cycles; optionally pokes a write/read in the last three.
    task automatic run_init(input bit poke);
        logic exp_busy;
        for (int i = 1; i <= 16; i++) begin
            if (poke && i >= 14) begin
                drv_wr(0, 4'd1, 16'hFFFF, 2'b11);
                drv_rd(0, 4'd1);
            end
            tick;
            exp_busy = (i < 16);
            checks++;
            if (busy0 !== exp_busy || busy1 !== exp_busy) begin
                failures++;
                $display("FAIL init_busy edge%0d: got %b/%b expected %b", i, busy0, busy1, exp_busy);
            end
            checks++;
            if (rvalid0 !== 4'b0 || rvalid1 !== 4'b0) begin
                failures++;
                $display("FAIL init_rvalid edge%0d: got %b/%b expected 0000", i, rvalid0, rvalid1);
            end
        end
        clr_in;
    endtask

    task automatic test_reset;
        clr_in;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rdata0 !== '0 || rvalid0 !== '0 || busy0 !== 1'b1 || coll0 !== 1'b0 || cnt0 !== 16'd0) begin
            failures++;
            $display("FAIL reset_dut0: rdata=%h rvalid=%b busy=%b coll=%b cnt=%h expected 0/0/1/0/0",
                     rdata0, rvalid0, busy0, coll0, cnt0);
        end
        checks++;
        if (rdata1 !== '0 || rvalid1 !== '0 || busy1 !== 1'b1 || coll1 !== 1'b0 || cnt1 !== 16'd0) begin
            failures++;
            $display("FAIL reset_dut1: rdata=%h rvalid=%b busy=%b coll=%b cnt=%h expected 0/0/1/0/0",
                     rdata1, rvalid1, busy1, coll1, cnt1);
        end
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_init;
        run_init(1'b1);
        for (int c = 0; c < 4; c++) begin
            clr_in;
            for (int k = 0; k < NR; k++) drv_rd(k, 4'(c*4 + k));
            tick;
            for (int k = 0; k < NR; k++) begin
                checks++;
                if (rvalid0[k] !== 1'b1 || rdata0[k*DW +: DW] !== 16'h0000) begin
                    failures++;
                    $display("FAIL init_read addr%0d: rdata=%h rvalid=%b expected 0000/1",
                             c*4 + k, rdata0[k*DW +: DW], rvalid0[k]);
                end
            end
        end
        clr_in;
        tick;
        checks++;
        if (rvalid1 !== 4'hF || rdata1 !== '0) begin
            failures++;
            $display("FAIL init_read_lat2: rdata=%h rvalid=%b expected 0/1111", rdata1, rvalid1);
        end
        tick;
    endtask

    task automatic test_byte_merge;
        clr_in;
        drv_wr(0, 4'd3, 16'hAA11, 2'b01);
        drv_wr(1, 4'd3, 16'hBB22, 2'b10);
        tick;
        checks++;
        if (coll0 !== 1'b0 || coll1 !== 1'b0) begin
            failures++;
            $display("FAIL merge_coll: got %b/%b expected 0", coll0, coll1);
        end
        clr_in;
        drv_rd(2, 4'd3);
        tick;
        checks++;
        if (rdata0[2*DW +: DW] !== 16'hBB11 || rvalid0[2] !== 1'b1) begin
            failures++;
            $display("FAIL merge_read: got %h/%b expected BB11/1", rdata0[2*DW +: DW], rvalid0[2]);
        end
        clr_in;
        tick;
        checks++;
        if (rdata1[2*DW +: DW] !== 16'hBB11 || rvalid1[2] !== 1'b1) begin
            failures++;
            $display("FAIL merge_read_lat2: got %h/%b expected BB11/1", rdata1[2*DW +: DW], rvalid1[2]);
        end
    endtask

    task automatic test_collision;
        clr_in;
        drv_wr(0, 4'd5, 16'h0011, 2'b11);
        drv_wr(2, 4'd5, 16'h0022, 2'b11);
        drv_wr(3, 4'd5, 16'h0033, 2'b11);
        tick;
        checks++;
        if (coll0 !== 1'b1 || cnt0 !== 16'd1 || coll1 !== 1'b1 || cnt1 !== 16'd1) begin
            failures++;
            $display("FAIL coll_pulse: coll=%b/%b cnt=%h/%h expected 1/1 0001", coll0, coll1, cnt0, cnt1);
        end
        clr_in;
        drv_rd(0, 4'd5);
        tick;
        checks++;
        if (coll0 !== 1'b0 || cnt0 !== 16'd1) begin
            failures++;
            $display("FAIL coll_after: coll=%b cnt=%h expected 0/0001", coll0, cnt0);
        end
        checks++;
        if (rdata0[DW-1:0] !== 16'h0011 || rvalid0[0] !== 1'b1) begin
            failures++;
            $display("FAIL coll_read: got %h/%b expected 0011/1", rdata0[DW-1:0], rvalid0[0]);
        end
        clr_in;
        tick;
        checks++;
        if (rdata1[DW-1:0] !== 16'h0011) begin
            failures++;
            $display("FAIL coll_read_lat2: got %h expected 0011", rdata1[DW-1:0]);
        end
    endtask

    task automatic test_rdw;
        clr_in;
        drv_wr(0, 4'd7, 16'h005A, 2'b11);
        tick;
        clr_in;
        drv_wr(1, 4'd7, 16'h00C3, 2'b11);
        drv_rd(3, 4'd7);
        tick;
        checks++;
        if (rdata0[3*DW +: DW] !== 16'h005A || rvalid0[3] !== 1'b1) begin
            failures++;
            $display("FAIL rdw_old: got %h/%b expected 005A/1", rdata0[3*DW +: DW], rvalid0[3]);
        end
        clr_in;
        drv_rd(3, 4'd7);
        tick;
        checks++;
        if (rdata0[3*DW +: DW] !== 16'h00C3) begin
            failures++;
            $display("FAIL rdw_next_read: got %h expected 00C3", rdata0[3*DW +: DW]);
        end
        checks++;
        if (rdata1[3*DW +: DW] !== 16'h00C3 || rvalid1[3] !== 1'b1) begin
            failures++;
            $display("FAIL rdw_new: got %h/%b expected 00C3/1", rdata1[3*DW +: DW], rvalid1[3]);
        end
        clr_in;
        tick;
        checks++;
        if (rdata1[3*DW +: DW] !== 16'h00C3 || rvalid1[3] !== 1'b1 || rvalid0[3] !== 1'b0) begin
            failures++;
            $display("FAIL rdw_second: got %h/%b rvalid0=%b expected 00C3/1/0",
                     rdata1[3*DW +: DW], rvalid1[3], rvalid0[3]);
        end
        tick;
    endtask

    task automatic test_latency;
        clr_in;
        drv_rd(1, 4'd3);
        tick;
        checks++;
        if (rvalid1[1] !== 1'b0 || rvalid0[1] !== 1'b1 || rdata0[DW +: DW] !== 16'hBB11) begin
            failures++;
            $display("FAIL lat_t0: rvalid1=%b rvalid0=%b rdata0=%h expected 0/1/BB11",
                     rvalid1[1], rvalid0[1], rdata0[DW +: DW]);
        end
        clr_in;
        tick;
        checks++;
        if (rvalid1[1] !== 1'b1 || rdata1[DW +: DW] !== 16'hBB11) begin
            failures++;
            $display("FAIL lat_t1: got %h/%b expected BB11/1", rdata1[DW +: DW], rvalid1[1]);
        end
        checks++;
        if (rvalid0[1] !== 1'b0 || rdata0[DW +: DW] !== 16'hBB11) begin
            failures++;
            $display("FAIL lat_hold1: got %h/%b expected BB11/0", rdata0[DW +: DW], rvalid0[1]);
        end
        tick;
        checks++;
        if (rvalid1[1] !== 1'b0 || rdata1[DW +: DW] !== 16'hBB11) begin
            failures++;
            $display("FAIL lat_hold2: got %h/%b expected BB11/0", rdata1[DW +: DW], rvalid1[1]);
        end
    endtask

    task automatic test_mid_reset;
        clr_in;
        drv_rd(0, 4'd7);
        drv_rd(1, 4'd5);
        tick;
        tick;
        checks++;
        if (rvalid1[1:0] !== 2'b11 || rdata1[DW-1:0] !== 16'h00C3) begin
            failures++;
            $display("FAIL inflight: rvalid=%b rdata=%h expected 11/00C3", rvalid1[1:0], rdata1[DW-1:0]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rdata0 !== '0 || rvalid0 !== '0 || busy0 !== 1'b1 || coll0 !== 1'b0 || cnt0 !== 16'd0 ||
            rdata1 !== '0 || rvalid1 !== '0 || busy1 !== 1'b1 || cnt1 !== 16'd0) begin
            failures++;
            $display("FAIL async_reset: rdata=%h/%h rvalid=%b/%b busy=%b/%b cnt=%h/%h expected 0/0/1/0",
                     rdata0, rdata1, rvalid0, rvalid1, busy0, busy1, cnt0, cnt1);
        end
        clr_in;
        tick;
        tick;
        rst = 1'b0;
        for (int i = 1; i <= 9; i++) tick;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy0 !== 1'b1 || rvalid0 !== '0 || rvalid1 !== '0) begin
            failures++;
            $display("FAIL midinit_reset: busy=%b rvalid=%b/%b expected 1/0/0", busy0, rvalid0, rvalid1);
        end
        tick;
        rst = 1'b0;
        run_init(1'b0);
        drv_rd(0, 4'd3);
        drv_rd(1, 4'd5);
        drv_rd(2, 4'd7);
        drv_rd(3, 4'd1);
        tick;
        checks++;
        if (rdata0 !== '0 || rvalid0 !== 4'hF) begin
            failures++;
            $display("FAIL post_reset_read: rdata=%h rvalid=%b expected 0/1111", rdata0, rvalid0);
        end
        clr_in;
        tick;
        checks++;
        if (rdata1 !== '0 || rvalid1 !== 4'hF) begin
            failures++;
            $display("FAIL post_reset_read_lat2: rdata=%h rvalid=%b expected 0/1111", rdata1, rvalid1);
        end
    endtask

    initial begin
        test_reset;
        test_init;
        test_byte_merge;
        test_collision;
        test_rdw;
        test_latency;
        test_mid_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
